// File: rtl/alu_issue_stage.sv
// ============================================================================
// alu_issue_stage
// ----------------------------------------------------------------------------
// ID->EX issue stage for an RV32I pipeline. Decodes OP / OP-IMM instructions
// into the 3-bit ALU select code and the two ALU operands. It holds the
// decoded payload in a 2-entry skid buffer (main + skid) with valid/ready
// handshakes on both sides. A synchronous flush kills everything buffered.
//
// Optional feature (compile-time macro):
//   ALU_ISSUE_UPPER_EN  when defined, LUI and AUIPC decode as ADD with a
//                       U-type immediate. AUIPC uses id_pc as operand1.
//                       When undefined, both opcodes are illegal and id_pc
//                       is ignored.
//
// Parameters:
//   XLEN       datapath width; only 32 is meaningful (shamt is instr[24:20])
//   ILL_CNT_W  width of the saturating illegal-instruction counter
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   flush                   kill both buffer entries next cycle, drop input
//   id_valid / id_ready     upstream handshake (id_ready is a flop)
//   id_instr                raw instruction word
//   id_rs1_data/rs2_data    forwarded register operands
//   id_pc                   instruction PC (AUIPC only)
//   ex_valid / ex_ready     downstream handshake
//   ex_operand1/operand2    ALU operands
//   ex_alusel               ALU select code
//   ex_rd, ex_we            destination register and its write enable
//   ex_illegal              instruction not decodable by this stage
//   ill_count               saturating count of accepted illegal instrs
// ============================================================================
module alu_issue_stage #(
    parameter int XLEN      = 32,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [31:0]          id_instr,
    input  logic [XLEN-1:0]      id_rs1_data,
    input  logic [XLEN-1:0]      id_rs2_data,
    input  logic [XLEN-1:0]      id_pc,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [XLEN-1:0]      ex_operand1,
    output logic [XLEN-1:0]      ex_operand2,
    output logic [2:0]           ex_alusel,
    output logic [4:0]           ex_rd,
    output logic                 ex_we,
    output logic                 ex_illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    // ------------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SLL = 3'b001,
        ALU_SUB = 3'b010,
        ALU_SRA = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SRL = 3'b101,
        ALU_OR  = 3'b110,
        ALU_AND = 3'b111
    } alusel_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        alusel_e         sel;
        logic [4:0]      rd;
        logic            we;
        logic            illegal;
    } payload_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
`ifdef ALU_ISSUE_UPPER_EN
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
`endif
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // ------------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd_field;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_shamt;

    assign opcode    = id_instr[6:0];
    assign funct3    = id_instr[14:12];
    assign funct7    = id_instr[31:25];
    assign rd_field  = id_instr[11:7];
    assign imm_i     = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};
    assign imm_shamt = {{(XLEN-5){1'b0}}, id_instr[24:20]};

`ifdef ALU_ISSUE_UPPER_EN
    logic [XLEN-1:0] imm_u;
    assign imm_u = XLEN'({id_instr[31:12], 12'b0});
`endif

    // The rs1 index is resolved in ID; here only its data is used.
`ifdef ALU_ISSUE_UPPER_EN
    logic unused_bits;
    assign unused_bits = ^id_instr[19:15];
`else
    logic unused_bits;
    assign unused_bits = ^{id_instr[19:15], id_pc};
`endif

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic            dec_legal;
    alusel_e         dec_sel;
    logic [XLEN-1:0] dec_op1;
    logic [XLEN-1:0] dec_op2;
    payload_t        dec;

    always_comb begin
        // NOTE: every variable gets a default before the case tree, so no
        // path leaves one unassigned and no latch is inferred.
        dec_legal = 1'b0;
        dec_sel   = ALU_ADD;
        dec_op1   = id_rs1_data;
        dec_op2   = id_rs2_data;

        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  begin dec_legal = 1'b1; dec_sel = ALU_ADD; end
                        3'b001:  begin dec_legal = 1'b1; dec_sel = ALU_SLL; end
                        3'b100:  begin dec_legal = 1'b1; dec_sel = ALU_XOR; end
                        3'b101:  begin dec_legal = 1'b1; dec_sel = ALU_SRL; end
                        3'b110:  begin dec_legal = 1'b1; dec_sel = ALU_OR;  end
                        3'b111:  begin dec_legal = 1'b1; dec_sel = ALU_AND; end
                        default: dec_legal = 1'b0;  // SLT/SLTU: no compare code
                    endcase
                end else if (funct7 == F7_ALT) begin
                    case (funct3)
                        3'b000:  begin dec_legal = 1'b1; dec_sel = ALU_SUB; end
                        3'b101:  begin dec_legal = 1'b1; dec_sel = ALU_SRA; end
                        default: dec_legal = 1'b0;
                    endcase
                end
            end

            OPC_OP_IMM: begin
                dec_op2 = imm_i;
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_sel = ALU_ADD; end
                    3'b100: begin dec_legal = 1'b1; dec_sel = ALU_XOR; end
                    3'b110: begin dec_legal = 1'b1; dec_sel = ALU_OR;  end
                    3'b111: begin dec_legal = 1'b1; dec_sel = ALU_AND; end
                    3'b001: begin
                        dec_op2 = imm_shamt;
                        if (funct7 == F7_BASE) begin
                            dec_legal = 1'b1;
                            dec_sel   = ALU_SLL;
                        end
                    end
                    3'b101: begin
                        // SRLI/SRAI share funct3; instr[30] picks the flavour,
                        // every other upper bit must be zero.
                        dec_op2 = imm_shamt;
                        if (funct7 == F7_BASE) begin
                            dec_legal = 1'b1;
                            dec_sel   = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec_legal = 1'b1;
                            dec_sel   = ALU_SRA;
                        end
                    end
                    default: dec_legal = 1'b0;  // SLTI/SLTIU
                endcase
            end

`ifdef ALU_ISSUE_UPPER_EN
            OPC_LUI: begin
                dec_legal = 1'b1;
                dec_sel   = ALU_ADD;
                dec_op1   = '0;
                dec_op2   = imm_u;
            end

            OPC_AUIPC: begin
                dec_legal = 1'b1;
                dec_sel   = ALU_ADD;
                dec_op1   = id_pc;
                dec_op2   = imm_u;
            end
`endif

            default: dec_legal = 1'b0;
        endcase

        // Illegal instructions still travel downstream, but with a neutral
        // payload so EX never computes on garbage operands.
        dec.op1     = dec_legal ? dec_op1 : '0;
        dec.op2     = dec_legal ? dec_op2 : '0;
        dec.sel     = dec_legal ? dec_sel : ALU_ADD;
        dec.rd      = rd_field;
        dec.we      = dec_legal && (rd_field != 5'd0);
        dec.illegal = !dec_legal;
    end

    // ------------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------------
    // id_ready is a flop derived from the next state, so it never depends
    // combinationally on ex_ready. The skid entry absorbs the one instruction
    // that can arrive in the cycle EX stalls.
    buf_state_e state;
    payload_t   main_q;
    payload_t   skid_q;
    logic       accept;

    assign accept = id_valid && id_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the payload entries are reset as well: main drives the
            // ex_* outputs, which must read zero out of reset, and resetting
            // skid keeps X from ever being copied into main.
            state    <= ST_EMPTY;
            ex_valid <= 1'b0;
            id_ready <= 1'b1;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            // Flush beats both accept and ex_ready; the input is dropped.
            state    <= ST_EMPTY;
            ex_valid <= 1'b0;
            id_ready <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q   <= dec;
                        state    <= ST_ONE;
                        ex_valid <= 1'b1;
                    end
                end

                ST_ONE: begin
                    if (accept && !ex_ready) begin
                        skid_q   <= dec;
                        state    <= ST_TWO;
                        id_ready <= 1'b0;
                    end else if (accept) begin
                        main_q   <= dec;  // pass-through: old main consumed
                    end else if (ex_ready) begin
                        state    <= ST_EMPTY;
                        ex_valid <= 1'b0;
                    end
                end

                ST_TWO: begin
                    // id_ready is low here, so no accept can coincide.
                    if (ex_ready) begin
                        main_q   <= skid_q;
                        state    <= ST_ONE;
                        id_ready <= 1'b1;
                    end
                end

                default: begin
                    state    <= ST_EMPTY;
                    ex_valid <= 1'b0;
                    id_ready <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Illegal-instruction counter (saturating; flushed input is not counted)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_count <= '0;
        end else if (accept && !flush && dec.illegal && (ill_count != '1)) begin
            ill_count <= ill_count + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // EX outputs come straight from the main entry
    // ------------------------------------------------------------------------
    assign ex_operand1 = main_q.op1;
    assign ex_operand2 = main_q.op2;
    assign ex_alusel   = main_q.sel;
    assign ex_rd       = main_q.rd;
    assign ex_we       = main_q.we;
    assign ex_illegal  = main_q.illegal;

endmodule
